// File: rtl/adc_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_seq_pkg : shared state encoding and defaults for adc_serial_seq      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV   = 3'd1,
    WAIT_H = 3'd2,
    WAIT_L = 3'd3,
    READ   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int c_data_w_def        = 16;
  localparam int c_clk_div_def       = 4;
  localparam int c_sample_period_def = 50000;
  localparam int c_convst_w_def      = 4;
  localparam int c_busy_timeout_def  = 5000;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_sclk_gen : SCLK divider, DATA_W periods per start, idles high        |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module adc_sclk_gen
  import adc_seq_pkg::*;
#(
  parameter int CLK_DIV = c_clk_div_def,
  parameter int DATA_W  = c_data_w_def
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        i_start,
  output logic                        o_sclk,
  output logic                        o_rise,
  output logic                        o_done,
  output logic [$clog2(DATA_W+1)-1:0] o_bit_cnt
);

  localparam int                 c_div_w    = cnt_w(CLK_DIV);
  localparam int                 c_bit_w    = $clog2(DATA_W + 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bits_all = c_bit_w'(DATA_W);

  logic               r_run;
  logic               r_sclk;
  logic [c_div_w-1:0] r_div;
  logic [c_bit_w-1:0] r_bits;
  logic               w_half_end;

  assign w_half_end = r_run && (r_div == c_div_last);
  assign o_rise     = w_half_end && !r_sclk;
  assign o_done     = w_half_end && r_sclk;
  assign o_sclk     = r_sclk;
  assign o_bit_cnt  = r_bits;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_run  <= 1'b0;
      r_sclk <= 1'b1;
      r_div  <= '0;
      r_bits <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_sclk <= 1'b0;
      r_div  <= '0;
      r_bits <= '0;
    end else if (r_run) begin
      if (w_half_end) begin
        r_div <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
          r_bits <= r_bits + 1'b1;
        end else if (r_bits == c_bits_all) begin
          // Final high phase complete: stop with SCLK parked high.
          r_run <= 1'b0;
        end else begin
          r_sclk <= 1'b0;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_serial_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_serial_seq : periodic CONVST/BUSY/serial-read sequencer for the ADC  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module adc_serial_seq
  import adc_seq_pkg::*;
#(
  parameter int DATA_W        = c_data_w_def,
  parameter int CLK_DIV       = c_clk_div_def,
  parameter int SAMPLE_PERIOD = c_sample_period_def,
  parameter int CONVST_W      = c_convst_w_def,
  parameter int BUSY_TIMEOUT  = c_busy_timeout_def
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              BUSY,
  input  logic              DATA,
  output logic              CS,
  output logic              CONVST,
  output logic              SCLK,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic              overrun,
  output logic              active
);

  localparam int                 c_per_w    = cnt_w(SAMPLE_PERIOD);
  localparam int                 c_tmo_w    = cnt_w(BUSY_TIMEOUT);
  localparam int                 c_cv_w     = cnt_w(CONVST_W);
  localparam int                 c_bit_w    = $clog2(DATA_W + 1);
  localparam logic [c_per_w-1:0] c_per_last = c_per_w'(SAMPLE_PERIOD - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(BUSY_TIMEOUT - 1);
  localparam logic [c_cv_w-1:0]  c_cv_last  = c_cv_w'(CONVST_W - 1);
  localparam logic [c_bit_w-1:0] c_bits_all = c_bit_w'(DATA_W);

  state_t              r_state;
  logic [c_per_w-1:0]  r_per_cnt;
  logic [c_tmo_w-1:0]  r_tmo_cnt;
  logic [c_cv_w-1:0]   r_cv_cnt;
  logic                r_busy_s1;
  logic                r_busy_s2;
  logic                r_en_d;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_sample;
  logic                r_cs;
  logic                r_convst;
  logic                r_valid;
  logic                r_terr;
  logic                r_ovr;

  logic                w_tick;
  logic                w_en_rise;
  logic                w_tmo_hit;
  logic                w_start;
  logic                w_rise;
  logic                w_done;
  logic [c_bit_w-1:0]  w_bit_cnt;

  assign w_tick    = en && (r_per_cnt == c_per_last);
  assign w_en_rise = en && !r_en_d;
  assign w_tmo_hit = (r_tmo_cnt == c_tmo_last);
  assign w_start   = (r_state == WAIT_L) && !r_busy_s2 && !w_tmo_hit;

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_sclk_gen (
    .clk       (clk),
    .nrst      (nrst),
    .i_start   (w_start),
    .o_sclk    (SCLK),
    .o_rise    (w_rise),
    .o_done    (w_done),
    .o_bit_cnt (w_bit_cnt)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_per_cnt <= '0;
      r_busy_s1 <= 1'b0;
      r_busy_s2 <= 1'b0;
      r_en_d    <= 1'b0;
      r_shift   <= '0;
    end else begin
      r_busy_s1 <= BUSY;
      r_busy_s2 <= r_busy_s1;
      r_en_d    <= en;
      if (!en || w_tick) r_per_cnt <= '0;
      else               r_per_cnt <= r_per_cnt + 1'b1;
      // DATA changes on SCLK fall, so it is settled at the rising edge.
      if (w_rise) r_shift <= {r_shift[DATA_W-2:0], DATA};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= IDLE;
      r_cv_cnt <= '0;
      r_tmo_cnt <= '0;
      r_cs     <= 1'b1;
      r_convst <= 1'b1;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_terr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_en_rise) begin
        r_terr <= 1'b0;
        r_ovr  <= 1'b0;
      end else if (w_tick && (r_state != IDLE)) begin
        r_ovr <= 1'b1;
      end
      case (r_state)
        IDLE: if (w_tick) begin
          r_state  <= CONV;
          r_convst <= 1'b0;
          r_cv_cnt <= '0;
        end
        CONV: if (r_cv_cnt == c_cv_last) begin
          r_state   <= WAIT_H;
          r_convst  <= 1'b1;
          r_tmo_cnt <= '0;
        end else begin
          r_cv_cnt <= r_cv_cnt + 1'b1;
        end
        // One timeout budget spans both BUSY phases.
        WAIT_H: if (w_tmo_hit) begin
          r_state <= IDLE;
          r_terr  <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          if (r_busy_s2) r_state <= WAIT_L;
        end
        WAIT_L: if (w_tmo_hit) begin
          r_state <= IDLE;
          r_terr  <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          if (!r_busy_s2) begin
            r_state <= READ;
            r_cs    <= 1'b0;
          end
        end
        READ: if (w_done && (w_bit_cnt == c_bits_all)) begin
          r_state <= DONE;
          r_cs    <= 1'b1;
        end
        DONE: begin
          r_sample <= r_shift;
          r_valid  <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign CS           = r_cs;
  assign CONVST       = r_convst;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign timeout_err  = r_terr;
  assign overrun      = r_ovr;
  assign active       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_adc_serial_seq : directed bench, two sequencers with behavioural ADCs |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_adc_serial_seq;

  localparam int DW   = 16;
  localparam int CD   = 2;
  localparam int CW   = 4;
  localparam int TMO  = 100;
  localparam int PER0 = 200;
  localparam int PER1 = 80;

  logic          clk  = 1'b0;
  logic          nrst = 1'b0;
  logic          en[2] = '{1'b0, 1'b0};
  logic          busy_on[2] = '{1'b1, 1'b1};
  logic [DW-1:0] adc_word[2];
  logic [DW-1:0] b2b[3] = '{16'h0000, 16'hFFFF, 16'h8001};
  int            busy_len = 40;

  logic          cs[2], convst[2], sclk[2], valid[2], terr[2], ovr[2], act[2];
  logic [DW-1:0] smp[2];
  wire           w_busy[2];
  wire           w_data[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_serial_seq #(
    .DATA_W(DW), .CLK_DIV(CD), .SAMPLE_PERIOD(PER0), .CONVST_W(CW), .BUSY_TIMEOUT(TMO)
  ) u_dut0 (
    .clk(clk), .nrst(nrst), .en(en[0]), .BUSY(w_busy[0]), .DATA(w_data[0]),
    .CS(cs[0]), .CONVST(convst[0]), .SCLK(sclk[0]), .sample(smp[0]),
    .sample_valid(valid[0]), .timeout_err(terr[0]), .overrun(ovr[0]), .active(act[0])
  );

  adc_serial_seq #(
    .DATA_W(DW), .CLK_DIV(CD), .SAMPLE_PERIOD(PER1), .CONVST_W(CW), .BUSY_TIMEOUT(TMO)
  ) u_dut1 (
    .clk(clk), .nrst(nrst), .en(en[1]), .BUSY(w_busy[1]), .DATA(w_data[1]),
    .CS(cs[1]), .CONVST(convst[1]), .SCLK(sclk[1]), .sample(smp[1]),
    .sample_valid(valid[1]), .timeout_err(terr[1]), .overrun(ovr[1]), .active(act[1])
  );

  // ADC model: BUSY after CONVST rises, MSB on CS fall, next bit on each SCLK fall.
  for (genvar gi = 0; gi < 2; gi++) begin : g_adc
    logic r_busy_m = 1'b0;
    logic r_data_m = 1'b0;
    int   n_rise   = DW;
    assign w_busy[gi] = r_busy_m;
    assign w_data[gi] = r_data_m;
    always @(posedge convst[gi]) begin
      if (busy_on[gi] && nrst) begin
        repeat (2) @(posedge clk);
        #1 r_busy_m = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 r_busy_m = 1'b0;
      end
    end
    always @(negedge cs[gi]) begin
      n_rise   = 0;
      r_data_m = adc_word[gi][DW-1];
    end
    always @(posedge cs[gi]) n_rise = DW;
    always @(posedge sclk[gi]) if (!cs[gi] && n_rise < DW) n_rise = n_rise + 1;
    always @(negedge sclk[gi]) if (!cs[gi] && n_rise < DW) r_data_m = adc_word[gi][DW-1-n_rise];
  end

  logic p_cs = 1'b1, p_sclk = 1'b1, p_convst = 1'b1, p_valid = 1'b0;
  int   rise_cnt = 0, rises_at_end = 0, low_run = 0, convst_w_last = 0;
  int   convst_falls = 0, valid_cnt = 0, dbl_valid = 0, cs_low_valid = 0, t_convst_rise = 0;

  always @(negedge clk) begin
    if (p_cs && !cs[0]) rise_cnt = 0;
    if (!p_sclk && sclk[0] && !cs[0]) rise_cnt = rise_cnt + 1;
    if (!p_cs && cs[0]) rises_at_end = rise_cnt;
    if (!convst[0]) low_run = low_run + 1;
    if (p_convst && !convst[0]) convst_falls = convst_falls + 1;
    if (!p_convst && convst[0]) begin
      convst_w_last = low_run;
      low_run       = 0;
      t_convst_rise = cyc;
    end
    if (valid[0]) begin
      valid_cnt = valid_cnt + 1;
      if (p_valid) dbl_valid = dbl_valid + 1;
      if (!cs[0]) cs_low_valid = cs_low_valid + 1;
    end
    p_cs     = cs[0];
    p_sclk   = sclk[0];
    p_convst = convst[0];
    p_valid  = valid[0];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int idx, input int budget);
    int n;
    n = 0;
    step();
    while (valid[idx] !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check_eq("valid_seen", {31'd0, valid[idx]}, 32'd1);
  endtask

  initial begin
    int n;
    int vsnap;
    int fsnap;
    int tdelta;
    adc_word[0] = 16'hA5C3;
    adc_word[1] = 16'h1234;
    repeat (3) step();
    check_eq("rst_cs",     cs[0],     32'd1);
    check_eq("rst_convst", convst[0], 32'd1);
    check_eq("rst_sclk",   sclk[0],   32'd1);
    check_eq("rst_sample", smp[0],    32'd0);
    check_eq("rst_valid",  valid[0],  32'd0);
    check_eq("rst_terr",   terr[0],   32'd0);
    check_eq("rst_ovr",    ovr[0],    32'd0);
    check_eq("rst_active", act[0],    32'd0);
    nrst = 1'b1;
    step();

    en[0] = 1'b1;
    wait_valid(0, 600);
    check_eq("t1_sample",   smp[0],        32'hA5C3);
    check_eq("t1_convst_w", convst_w_last, CW);
    check_eq("t1_rises",    rises_at_end,  DW);

    for (int i = 0; i < 3; i++) begin
      adc_word[0] = b2b[i];
      wait_valid(0, 400);
      check_eq("b2b_sample", smp[0], {16'd0, b2b[i]});
    end
    check_eq("b2b_rises", rises_at_end, DW);

    busy_on[0] = 1'b0;
    vsnap = valid_cnt;
    fsnap = convst_falls;
    n = 0;
    while (terr[0] !== 1'b1 && n < 400) begin step(); n++; end
    tdelta = cyc - t_convst_rise;
    check_eq("tmo_flag",    terr[0],   32'd1);
    check_eq("tmo_delay",   tdelta,    TMO);
    check_eq("tmo_active",  act[0],    32'd0);
    check_eq("tmo_novalid", valid_cnt, vsnap);
    n = 0;
    while (convst_falls < fsnap + 2 && n < 400) begin step(); n++; end
    check_eq("tmo_retry",  convst_falls, fsnap + 2);
    check_eq("tmo_sticky", terr[0],      32'd1);
    n = 0;
    while (act[0] !== 1'b0 && n < 300) begin step(); n++; end
    en[0] = 1'b0;
    repeat (3) step();
    en[0] = 1'b1;
    repeat (2) step();
    check_eq("tmo_clear", terr[0], 32'd0);
    busy_on[0] = 1'b1;

    adc_word[0] = 16'h3C5A;
    n = 0;
    while (w_busy[0] !== 1'b1 && n < 400) begin step(); n++; end
    repeat (10) step();
    en[0] = 1'b0;
    wait_valid(0, 300);
    check_eq("endrop_sample", smp[0], 32'h3C5A);
    fsnap = convst_falls;
    repeat (3 * PER0) step();
    check_eq("endrop_noconv", convst_falls, fsnap);
    check_eq("endrop_idle",   act[0],       32'd0);

    adc_word[0] = 16'h6B1D;
    en[0] = 1'b1;
    n = 0;
    while (!(rise_cnt == 7 && cs[0] === 1'b0) && n < 600) begin step(); n++; end
    check_eq("rst_mid_bit7", rise_cnt, 32'd7);
    vsnap = valid_cnt;
    nrst = 1'b0;
    #1;
    check_eq("rstm_cs",     cs[0],     32'd1);
    check_eq("rstm_sclk",   sclk[0],   32'd1);
    check_eq("rstm_convst", convst[0], 32'd1);
    check_eq("rstm_valid",  valid[0],  32'd0);
    check_eq("rstm_active", act[0],    32'd0);
    check_eq("rstm_sample", smp[0],    32'd0);
    repeat (2) step();
    nrst = 1'b1;
    wait_valid(0, 700);
    check_eq("rstm_after_sample", smp[0], 32'h6B1D);
    step();
    check_eq("rstm_one_valid", valid_cnt, vsnap + 1);

    en[1] = 1'b1;
    wait_valid(1, 400);
    check_eq("ovr_sample1", smp[1], 32'h1234);
    check_eq("ovr_flag",    ovr[1], 32'd1);
    adc_word[1] = 16'h5678;
    wait_valid(1, 400);
    check_eq("ovr_sample2", smp[1],  32'h5678);
    check_eq("ovr_no_tmo",  terr[1], 32'd0);
    en[1] = 1'b0;

    check_eq("valid_single",     dbl_valid,    32'd0);
    check_eq("cs_high_at_valid", cs_low_valid, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
